// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline interlock and forwarding controller for the 5-stage core. It keeps
//   a shadow scoreboard of the destination registers held in EX, MEM and WB.
//   From that scoreboard it produces the decode-stage RAW hazard bus, the
//   operand forward selects, the fetch/decode stall and flush strobes, and two
//   saturating event counters.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active-low
//   dec_valid                decode holds a real instruction
//   dec_rs1/dec_rs2          decode source registers
//   dec_use_rs1/dec_use_rs2  the source is actually read
//   dec_rd                   decode destination register
//   dec_rf_wb                decode instruction writes the register file
//   dec_is_load              decode instruction is a load
//   ex_redirect              branch/jump redirect resolved in EX this cycle
//   mem_stall                data memory busy, freeze the whole pipe
//   raw_hazards              {rs2_mem, rs1_mem, rs2_ex, rs1_ex}
//   fwd_sel_a/fwd_sel_b      00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_if/stall_dec       hold PC and IF/DEC register
//   flush_if/flush_dec       squash IF/DEC, bubble into EX
//   stall_cnt/flush_cnt      saturating event counters
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_use_rs1,
    input  logic                  dec_use_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_rf_wb,
    input  logic                  dec_is_load,
    input  logic                  ex_redirect,
    input  logic                  mem_stall,
    output logic [3:0]            raw_hazards,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall_if,
    output logic                  stall_dec,
    output logic                  flush_if,
    output logic                  flush_dec,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic                    ex_we_q, ex_we_d, mem_we_q, mem_we_d, wb_we_q, wb_we_d;
    logic                    ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic ex_live, mem_live, wb_live;
    logic rs1_nz, rs2_nz;
    logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2, hit_wb_rs1, hit_wb_rs2;
    logic load_use, issue, stall_w, flush_w, lu_event;
    logic [1:0] sel_a, sel_b;

    // A scoreboard entry targeting x0 never produces a hazard.
    always_comb begin
        ex_live     = ex_we_q  & (ex_rd_q  != '0);
        mem_live    = mem_we_q & (mem_rd_q != '0);
        wb_live     = wb_we_q  & (wb_rd_q  != '0);
        rs1_nz      = (dec_rs1 != '0);
        rs2_nz      = (dec_rs2 != '0);
        hit_ex_rs1  = dec_valid & dec_use_rs1 & ex_live  & (ex_rd_q  == dec_rs1) & rs1_nz;
        hit_ex_rs2  = dec_valid & dec_use_rs2 & ex_live  & (ex_rd_q  == dec_rs2) & rs2_nz;
        hit_mem_rs1 = dec_valid & dec_use_rs1 & mem_live & (mem_rd_q == dec_rs1) & rs1_nz;
        hit_mem_rs2 = dec_valid & dec_use_rs2 & mem_live & (mem_rd_q == dec_rs2) & rs2_nz;
        hit_wb_rs1  = dec_valid & dec_use_rs1 & wb_live  & (wb_rd_q  == dec_rs1) & rs1_nz;
        hit_wb_rs2  = dec_valid & dec_use_rs2 & wb_live  & (wb_rd_q  == dec_rs2) & rs2_nz;
        load_use    = ex_ld_q & (hit_ex_rs1 | hit_ex_rs2);
        issue       = dec_valid & ~load_use & ~ex_redirect;
        stall_w     = mem_stall | (load_use & ~ex_redirect);
        flush_w     = ex_redirect & ~mem_stall;
        lu_event    = load_use & ~ex_redirect & ~mem_stall;
    end

    // Youngest producer wins. The register file is not write-through, so a
    // WB hit still needs its own forward path. While a load-use bubble is
    // being inserted the operands are about to be re-read, so select 00.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (!load_use) begin
            if (hit_ex_rs1)       sel_a = 2'b01;
            else if (hit_mem_rs1) sel_a = 2'b10;
            else if (hit_wb_rs1)  sel_a = 2'b11;
            if (hit_ex_rs2)       sel_b = 2'b01;
            else if (hit_mem_rs2) sel_b = 2'b10;
            else if (hit_wb_rs2)  sel_b = 2'b11;
        end
    end

    // Strobes are gated by reset so the block is quiet while held in reset,
    // whatever the rest of the pipe is driving.
    assign raw_hazards = {hit_mem_rs2, hit_mem_rs1, hit_ex_rs2, hit_ex_rs1};
    assign fwd_sel_a   = sel_a;
    assign fwd_sel_b   = sel_b;
    assign stall_if    = rst & stall_w;
    assign stall_dec   = rst & stall_w;
    assign flush_if    = rst & flush_w;
    assign flush_dec   = rst & flush_w;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        state_d     = state_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_ld_d     = ex_ld_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        mem_ld_d    = mem_ld_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // A freeze overrides everything; a load-use stall lasts one cycle
        // because the bubble moves the load into MEM where it forwards.
        case (state_q)
            RUN: begin
                if (mem_stall)     state_d = FROZEN;
                else if (lu_event) state_d = LU_STALL;
            end
            LU_STALL: state_d = mem_stall ? FROZEN : RUN;
            FROZEN:   state_d = mem_stall ? FROZEN : RUN;
            default:  state_d = RUN;
        endcase

        if (!mem_stall) begin
            wb_rd_d  = mem_rd_q;
            wb_we_d  = mem_we_q;
            mem_rd_d = ex_rd_q;
            mem_we_d = ex_we_q;
            mem_ld_d = ex_ld_q;
            if (issue) begin
                ex_rd_d = dec_rd;
                ex_we_d = dec_rf_wb;
                ex_ld_d = dec_is_load;
            end else begin
                ex_rd_d = '0;
                ex_we_d = 1'b0;
                ex_ld_d = 1'b0;
            end
        end

        if (lu_event && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_w && flush_cnt_q != CNT_MAX)  flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_ld_q    <= mem_ld_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with hand-computed expectations. The DUT is
//   built with a 2-bit counter width so that counter saturation is reachable.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          dec_valid;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic          dec_use_rs1;
    logic          dec_use_rs2;
    logic [AW-1:0] dec_rd;
    logic          dec_rf_wb;
    logic          dec_is_load;
    logic          ex_redirect;
    logic          mem_stall;
    logic [3:0]    raw_hazards;
    logic [1:0]    fwd_sel_a;
    logic [1:0]    fwd_sel_b;
    logic          stall_if;
    logic          stall_dec;
    logic          flush_if;
    logic          flush_dec;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    logic prev_lu = 1'b0;
    logic cur_lu;

    hazard_ctrl #(
        .REG_ADDR_W(AW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_use_rs1(dec_use_rs1),
        .dec_use_rs2(dec_use_rs2),
        .dec_rd     (dec_rd),
        .dec_rf_wb  (dec_rf_wb),
        .dec_is_load(dec_is_load),
        .ex_redirect(ex_redirect),
        .mem_stall  (mem_stall),
        .raw_hazards(raw_hazards),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall_if   (stall_if),
        .stall_dec  (stall_dec),
        .flush_if   (flush_if),
        .flush_dec  (flush_dec),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkStrobes(input string tag, input int exp_stall, input int exp_flush);
        checkOutput({tag, "_stall_if"},  32'(stall_if),  32'(exp_stall));
        checkOutput({tag, "_stall_dec"}, 32'(stall_dec), 32'(exp_stall));
        checkOutput({tag, "_flush_if"},  32'(flush_if),  32'(exp_flush));
        checkOutput({tag, "_flush_dec"}, 32'(flush_dec), 32'(exp_flush));
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the
    // following falling edge.
    task automatic applyStimulus(input int valid, input int rs1, input int use1,
                                 input int rs2, input int use2, input int rd,
                                 input int wb, input int ld, input int redir,
                                 input int mstall);
        @(posedge clk);
        #1;
        dec_valid   = 1'(valid);
        dec_rs1     = AW'(rs1);
        dec_use_rs1 = 1'(use1);
        dec_rs2     = AW'(rs2);
        dec_use_rs2 = 1'(use2);
        dec_rd      = AW'(rd);
        dec_rf_wb   = 1'(wb);
        dec_is_load = 1'(ld);
        ex_redirect = 1'(redir);
        mem_stall   = 1'(mstall);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // A load-use stall can never follow another one directly: the first
    // stall always puts a bubble into EX.
    always @(negedge clk) begin
        cur_lu = rst && stall_if && !mem_stall;
        if (rst) begin
            assert (!(prev_lu && cur_lu)) else begin
                errors++;
                $display("[TB] FAIL lu_b2b: got back-to-back load-use stall expected single");
            end
        end
        prev_lu = cur_lu;
    end

    initial begin
        rst         = 1'b0;
        dec_valid   = 1'b0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_rd      = '0;
        dec_rf_wb   = 1'b0;
        dec_is_load = 1'b0;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;

        // Held in reset with random inputs: every output reads 0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            dec_valid   = 1'($urandom);
            dec_rs1     = AW'($urandom);
            dec_rs2     = AW'($urandom);
            dec_use_rs1 = 1'($urandom);
            dec_use_rs2 = 1'($urandom);
            dec_rd      = AW'($urandom);
            dec_rf_wb   = 1'($urandom);
            dec_is_load = 1'($urandom);
            ex_redirect = 1'($urandom);
            mem_stall   = 1'($urandom);
            @(negedge clk);
            checkOutput("rst_raw",   32'(raw_hazards), 0);
            checkOutput("rst_fwd_a", 32'(fwd_sel_a), 0);
            checkOutput("rst_fwd_b", 32'(fwd_sel_b), 0);
            checkStrobes("rst", 0, 0);
            checkOutput("rst_stall_cnt", 32'(stall_cnt), 0);
            checkOutput("rst_flush_cnt", 32'(flush_cnt), 0);
        end
        @(posedge clk);
        #1;
        dec_valid   = 1'b0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_rf_wb   = 1'b0;
        dec_is_load = 1'b0;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        checkOutput("rel_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("rel_flush_cnt", 32'(flush_cnt), 0);
        checkStrobes("rel", 0, 0);

        // ALU chain: add x5, then a reader of x5 for three cycles.
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        checkOutput("alu0_raw", 32'(raw_hazards), 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu1_raw",   32'(raw_hazards), 32'h1);
        checkOutput("alu1_fwd_a", 32'(fwd_sel_a), 1);
        checkOutput("alu1_fwd_b", 32'(fwd_sel_b), 0);
        checkStrobes("alu1", 0, 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu2_raw",   32'(raw_hazards), 32'h4);
        checkOutput("alu2_fwd_a", 32'(fwd_sel_a), 2);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu3_raw",   32'(raw_hazards), 0);
        checkOutput("alu3_fwd_a", 32'(fwd_sel_a), 3);
        idle(3);

        // Load-use: lw x7, then add reading x7 through rs2.
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        checkStrobes("lu0", 0, 0);
        applyStimulus(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
        checkOutput("lu1_raw",   32'(raw_hazards), 32'h2);
        checkOutput("lu1_fwd_b", 32'(fwd_sel_b), 0);
        checkStrobes("lu1", 1, 0);
        checkOutput("lu1_stall_cnt", 32'(stall_cnt), 0);
        applyStimulus(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
        checkOutput("lu2_raw",   32'(raw_hazards), 32'h8);
        checkOutput("lu2_fwd_b", 32'(fwd_sel_b), 2);
        checkStrobes("lu2", 0, 0);
        checkOutput("lu2_stall_cnt", 32'(stall_cnt), 1);
        idle(1);
        checkStrobes("lu3", 0, 0);
        checkOutput("lu3_stall_cnt", 32'(stall_cnt), 1);
        idle(3);

        // x0 is never a hazard.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("x0_raw",   32'(raw_hazards), 0);
        checkOutput("x0_fwd_a", 32'(fwd_sel_a), 0);
        checkOutput("x0_fwd_b", 32'(fwd_sel_b), 0);
        checkStrobes("x0", 0, 0);
        idle(3);

        // Redirect together with load-use: redirect wins.
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1, 0);
        checkStrobes("rdlu", 0, 1);
        checkOutput("rdlu_raw",   32'(raw_hazards), 32'h1);
        checkOutput("rdlu_fwd_a", 32'(fwd_sel_a), 0);
        checkOutput("rdlu_flush_cnt", 32'(flush_cnt), 0);
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdlu1_raw",   32'(raw_hazards), 32'h4);
        checkOutput("rdlu1_fwd_a", 32'(fwd_sel_a), 2);
        checkStrobes("rdlu1", 0, 0);
        checkOutput("rdlu1_flush_cnt", 32'(flush_cnt), 1);
        checkOutput("rdlu1_stall_cnt", 32'(stall_cnt), 1);
        // Redirect squashes an ALU writer of x10: EX holds a bubble next.
        applyStimulus(1, 0, 0, 0, 0, 10, 1, 0, 1, 0);
        checkStrobes("rd", 0, 1);
        applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd1_raw",   32'(raw_hazards), 0);
        checkOutput("rd1_fwd_a", 32'(fwd_sel_a), 0);
        checkOutput("rd1_flush_cnt", 32'(flush_cnt), 2);
        idle(3);

        // mem_stall with a pending redirect: freeze wins, flush on release.
        applyStimulus(1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 1, 1);
            checkOutput("ms_raw",   32'(raw_hazards), 32'h1);
            checkOutput("ms_fwd_a", 32'(fwd_sel_a), 1);
            checkStrobes("ms", 1, 0);
            checkOutput("ms_flush_cnt", 32'(flush_cnt), 2);
        end
        applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 1, 0);
        checkStrobes("msrel", 0, 1);
        checkOutput("msrel_raw", 32'(raw_hazards), 32'h1);
        applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        checkStrobes("msrel1", 0, 0);
        checkOutput("msrel1_flush_cnt", 32'(flush_cnt), 3);
        checkOutput("msrel1_raw",   32'(raw_hazards), 32'h4);
        checkOutput("msrel1_fwd_a", 32'(fwd_sel_a), 2);
        // Further flushes saturate the 2-bit counter.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkStrobes("sat0", 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        checkOutput("sat_flush_cnt", 32'(flush_cnt), 3);
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 1);
        idle(3);

        // Asynchronous reset in the middle of operation.
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
        applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_raw", 32'(raw_hazards), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_raw",   32'(raw_hazards), 0);
        checkOutput("mid_rst_fwd_a", 32'(fwd_sel_a), 0);
        checkOutput("mid_rst_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("mid_rst_flush_cnt", 32'(flush_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        checkOutput("post_raw", 32'(raw_hazards), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
